// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one combinational adder between two requesters as a multicycle path.
// Optional feature macro: ADDER_ARB_RR_EN (round-robin tie-break; fixed priority to requester 0 otherwise).
// Ports:
//   Clk, Reset (async, active-low)
//   req0/a0/b0, req1/a1/b1  : requests with operands, held until the matching gnt pulse
//   gnt0, gnt1              : one-cycle accept pulse
//   busy                    : addition in flight
//   done, done_id           : one-cycle result-valid pulse and owning requester
//   result, result_co       : registered sum and carry-out, held until the next done
//   add_a, add_b            : registered operands driven to the adder
//   add_sum, add_co         : adder outputs
module adder_arbiter #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             result_co,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_co
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       id;
  logic       win;
`ifdef ADDER_ARB_RR_EN
  logic lg;
  // on a tie the requester that did not win last time goes next
  assign win = (req0 && req1) ? ~lg : ~req0;
`else
  assign win = ~req0;
`endif
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      id        <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      result    <= '0;
      result_co <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
`ifdef ADDER_ARB_RR_EN
      lg        <= 1'b1;
`endif
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (req0 || req1) begin
          id    <= win;
          add_a <= win ? a1 : a0;
          add_b <= win ? b1 : b0;
          cnt   <= 4'(SETTLE - 1);
          busy  <= 1'b1;
          gnt0  <= ~win;
          gnt1  <= win;
          state <= RUN;
        end
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        result    <= add_sum;
        result_co <= add_co;
        done      <= 1'b1;
        done_id   <= id;
        busy      <= 1'b0;
`ifdef ADDER_ARB_RR_EN
        lg        <= id;
`endif
        state     <= IDLE;
      end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: randomized self-checking bench for adder_arbiter against a transaction-level model.
module tb_adder_arbiter;
  localparam int WIDTH  = 16;
  localparam int SETTLE = 2;
  logic             Clk = 1'b0, Reset = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic             gnt0, gnt1, busy, done, done_id, result_co, add_co;
  logic [WIDTH-1:0] result, add_a, add_b, add_sum;
  logic             q0 = 1'b0;
  logic [WIDTH-1:0] qa = '0, qb = '0;
  logic             s_gnt0, s_gnt1, s_busy, s_done, s_id, s_co, s_aco;
  logic [WIDTH-1:0] s_res, s_aa, s_ab, s_sum;
  int               errors = 0, checks = 0;
  logic             lg_m = 1'b1;

  adder_arbiter #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .result_co(result_co), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_co(add_co)
  );

  adder_arbiter #(.WIDTH(WIDTH), .SETTLE(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .req0(q0), .a0(qa), .b0(qb), .req1(1'b0), .a1('0), .b1('0),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .busy(s_busy), .done(s_done), .done_id(s_id),
    .result(s_res), .result_co(s_co), .add_a(s_aa), .add_b(s_ab),
    .add_sum(s_sum), .add_co(s_aco)
  );

  always #5 Clk = ~Clk;
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b};
  assign {s_aco, s_sum}    = {1'b0, s_aa} + {1'b0, s_ab};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic exp_win(input logic r0, input logic r1);
`ifdef ADDER_ARB_RR_EN
    if (r0 && r1) return (lg_m == 1'b1) ? 1'b0 : 1'b1;
`endif
    return r0 ? 1'b0 : 1'b1;
  endfunction

  task automatic run_txn(input logic r0, input logic r1, input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                         input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1);
    logic w;
    logic [WIDTH:0] s;
    logic [WIDTH-1:0] ea, eb;
    int n;
    w  = exp_win(r0, r1);
    ea = w ? x1 : x0;
    eb = w ? y1 : y0;
    s  = {1'b0, ea} + {1'b0, eb};
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    n = 0;
    do begin tick(); n++; end while (!gnt0 && !gnt1 && n < 8);
    checks++;
    if ({n == 1, gnt0, gnt1, busy, done, add_a, add_b} !== {1'b1, ~w, w, 1'b1, 1'b0, ea, eb}) begin
      errors++;
      $display("FAIL grant: lat=%0d gnt0=%b gnt1=%b busy=%b done=%b add_a=%h add_b=%h want lat=1 gnt0=%b gnt1=%b busy=1 done=0 add_a=%h add_b=%h",
               n, gnt0, gnt1, busy, done, add_a, add_b, ~w, w, ea, eb);
    end
    req0 = 1'b0; req1 = 1'b0;
    a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
    for (int k = 1; k < SETTLE; k++) begin
      tick();
      checks++;
      if ({gnt0, gnt1, busy, done, add_a, add_b} !== {3'b001, 1'b0, ea, eb}) begin
        errors++;
        $display("FAIL settle%0d: gnt0=%b gnt1=%b busy=%b done=%b add_a=%h add_b=%h want 0 0 1 0 %h %h",
                 k, gnt0, gnt1, busy, done, add_a, add_b, ea, eb);
      end
    end
    tick();
    checks++;
    if ({done, busy, gnt0, gnt1, done_id, result_co, result, add_a} !== {4'b1000, w, s, ea}) begin
      errors++;
      $display("FAIL done: done=%b busy=%b gnt=%b%b id=%b co=%b result=%h add_a=%h want 1 0 00 id=%b co=%b result=%h add_a=%h",
               done, busy, gnt0, gnt1, done_id, result_co, result, add_a, w, s[WIDTH], s[WIDTH-1:0], ea);
    end
    lg_m = w;
    tick();
    checks++;
    if ({done, busy, gnt0, gnt1, result_co, result} !== {4'b0000, s}) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b gnt=%b%b co=%b result=%h want 0 0 00 co=%b result=%h",
               done, busy, gnt0, gnt1, result_co, result, s[WIDTH], s[WIDTH-1:0]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({gnt0, gnt1, busy, done, done_id, result_co, result, add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b%b busy=%b done=%b id=%b co=%b result=%h add_a=%h add_b=%h want all 0",
               gnt0, gnt1, busy, done, done_id, result_co, result, add_a, add_b);
    end
    checks++;
    if ({s_gnt0, s_gnt1, s_busy, s_done, s_id, s_co, s_res, s_aa, s_ab} !== '0) begin
      errors++;
      $display("FAIL reset_s1: gnt=%b%b busy=%b done=%b res=%h want all 0", s_gnt0, s_gnt1, s_busy, s_done, s_res);
    end
  endtask

  task automatic test_single();
    run_txn(1'b1, 1'b0, 16'hFFFF, 16'h0001, WIDTH'($urandom), WIDTH'($urandom));
  endtask

  task automatic test_reset_mid_run();
    req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0001;
    tick();
    checks++;
    if ({gnt0, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rst_grant: gnt0=%b busy=%b want 1 1", gnt0, busy);
    end
    req0 = 1'b0;
    #2 Reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({gnt0, gnt1, busy, done, done_id, result_co, result, add_a, add_b} !== '0) begin
        errors++;
        $display("FAIL rst_mid%0d: gnt=%b%b busy=%b done=%b result=%h add_a=%h add_b=%h want all 0",
                 k, gnt0, gnt1, busy, done, result, add_a, add_b);
      end
      tick();
    end
    Reset = 1'b1;
    lg_m = 1'b1;
    run_txn(1'b1, 1'b0, 16'h1234, 16'h0001, 16'h0, 16'h0);
  endtask

  task automatic test_both_held();
    logic id_w;
    logic [WIDTH-1:0] rs;
    int seen, cyc;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    lg_m = 1'b1;
    req0 = 1'b1; req1 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; a1 = 16'h0003; b1 = 16'h0004;
    seen = 0; cyc = 0;
    while (seen < 4 && cyc < 4 * (SETTLE + 1) + 4) begin
      tick();
      cyc++;
      checks++;
      if (done && (busy || gnt0 || gnt1)) begin
        errors++;
        $display("FAIL overlap: done=%b busy=%b gnt=%b%b want done alone", done, busy, gnt0, gnt1);
      end
      if (done) begin
        id_w = exp_win(1'b1, 1'b1);
        rs = id_w ? 16'h0007 : 16'h0003;
        checks++;
        if ({done_id, result} !== {id_w, rs}) begin
          errors++;
          $display("FAIL tie%0d: id=%b result=%h want id=%b result=%h", seen, done_id, result, id_w, rs);
        end
        lg_m = id_w;
        seen++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (seen != 4 || cyc != 4 * (SETTLE + 1)) begin
      errors++;
      $display("FAIL tie_rate: dones=%0d cycles=%0d want dones=4 cycles=%0d", seen, cyc, 4 * (SETTLE + 1));
    end
    tick();
    checks++;
    if ({busy, gnt0, gnt1, done} !== 4'b0000) begin
      errors++;
      $display("FAIL tie_idle: busy=%b gnt=%b%b done=%b want 0", busy, gnt0, gnt1, done);
    end
  endtask

  task automatic test_drop_before_grant();
    int nd, ng1;
    req0 = 1'b1; a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL drop_grant: gnt=%b%b want 10", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b1; a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
    tick();
    req1 = 1'b0;
    nd = 0; ng1 = 0;
    for (int k = 0; k < SETTLE + 4; k++) begin
      tick();
      nd += int'(done);
      ng1 += int'(gnt1);
    end
    lg_m = 1'b0;
    checks++;
    if (nd != 1 || ng1 != 0) begin
      errors++;
      $display("FAIL drop: dones=%0d gnt1s=%0d want dones=1 gnt1s=0", nd, ng1);
    end
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int i = 0; i < 24; i++) begin
      r = 2'($urandom_range(1, 3));
      run_txn(r[0], r[1], WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    q0 = 1'b1; qa = 16'h8000; qb = 16'h8001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (i % 2 == 1) begin
        if ({s_gnt0, s_done, s_busy} !== 3'b101) begin
          errors++;
          $display("FAIL b2b_gnt%0d: gnt=%b done=%b busy=%b want 1 0 1", i, s_gnt0, s_done, s_busy);
        end
      end else if ({s_gnt0, s_done, s_busy, s_co, s_res} !== {3'b010, 1'b1, 16'h0001}) begin
        errors++;
        $display("FAIL b2b_done%0d: gnt=%b done=%b busy=%b co=%b res=%h want 0 1 0 co=1 res=0001",
                 i, s_gnt0, s_done, s_busy, s_co, s_res);
      end
    end
    q0 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    Reset = 1'b1;
    test_single();
    test_reset_mid_run();
    test_both_held();
    test_drop_before_grant();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one combinational 16-bit adder (ripple, carry-lookahead or carry-select) between two requesters. Captures a winner's operands, holds them on the adder for a fixed settle window, registers sum and carry-out, and returns them with a done pulse. It sits between the adder instance and the blocks that need additions, so the adder can be timed as a multicycle path.

## Interface
- WIDTH, 16, operand/result width; matches the adder instance.
- SETTLE, 2, cycles adder inputs are held stable before capture; legal 1..15.

- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- req0  in  1  requester 0 request; held with operands until gnt0.
- a0, b0  in  WIDTH each  requester 0 operands.
- req1  in  1  requester 1 request.
- a1, b1  in  WIDTH each  requester 1 operands.
- gnt0, gnt1  out  1 each  one-cycle accept pulse; operands were latched.
- busy  out  1  high while an addition is in flight.
- done  out  1  one-cycle pulse; result/result_co valid.
- done_id  out  1  requester owning the current result (0/1).
- result  out  WIDTH  registered sum; holds until next done.
- result_co  out  1  registered carry-out; holds until next done.
- add_a, add_b  out  WIDTH each  registered operands driven to the adder.
- add_sum  in  WIDTH  adder sum.
- add_co  in  1  adder carry-out.

## Operation
- FSM states: IDLE, RUN; down-counter cnt (4 bits); last-grant pointer lg.
- IDLE, no request: outputs hold; gnt*, done low.
- IDLE, ≥1 request at edge: select winner; load add_a/add_b from winner; cnt ← SETTLE-1; busy←1; gntX←1 for the following cycle; → RUN.
- RUN, cnt≠0: cnt decrements; add_a/add_b stable; requests ignored; gnt* low.
- RUN, cnt=0 at edge: result←add_sum, result_co←add_co, done←1 for one cycle, done_id←winner, busy←0, lg←winner; → IDLE.
- A request asserted during RUN is not lost. It is served from IDLE only if req is still held.
- A request dropped before its grant is never served.
- Requesters must drop req within the gnt cycle or they are served again.
- Arbitration with both requests: see Configuration; a single request always wins.
- Reset (any time, including mid-RUN) returns all outputs to 0, state IDLE, lg←1. In-flight operation is discarded and no done is issued.
- Carry beyond WIDTH appears only on result_co; result wraps modulo 2^WIDTH.

## Timing
- Request sampled at edge e0; gnt high in cycle e0→e1.
- add_a/add_b stable from e0 through capture edge e(SETTLE).
- done high in cycle e(SETTLE)→e(SETTLE+1).
- IDLE is re-entered at e(SETTLE). The next request is sampled at e(SETTLE+1), so peak throughput is one addition per SETTLE+1 cycles.
- done and the next gnt never overlap; done and busy are never both high.

## Configuration
- ADDER_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the requester ≠ lg. Requester 0 wins first after reset (lg=1).
- Not defined: fixed priority; requester 0 always wins ties, lg unused.

## Test plan
- Reset mid-RUN (SETTLE=2, req0 a0=16'h1234 b0=16'h0001, Reset low after gnt0) -> done never pulses; all outputs 0; next req served normally.
- Single request, SETTLE=2: req0, a0=16'hFFFF, b0=16'h0001 at e0 -> gnt0 in e0→e1; add_a=FFFF through e2; done at e2→e3 with result=0000, result_co=1, done_id=0.
- Both requests held continuously, ADDER_ARB_RR_EN defined, a0+b0=16'h0003, a1+b1=16'h0007 -> dones alternate id 0,1,0,1 with results 0003/0007. Without the macro, only id 0 completes.
- Request dropped before grant: req1 pulses one cycle during RUN -> no gnt1, no extra done.
- SETTLE=1 back-to-back req0 -> gnt0 every 2 cycles; each done exactly 1 cycle after its gnt.
